// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch unit with a DEPTH-entry prefetch queue.
// Owns the PC, issues one-word reads when queue space is guaranteed, buffers
// returned {pc, insn} pairs and hands them to decode over valid/ready.
// Optional feature macro: FETCHQ_STALL_COUNT_EN adds a saturating 32-bit
// stall_count output counting cycles where decode waits on an empty queue.
module fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h8002_0000,
  parameter int                    PC_STEP    = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable_fetch,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  output logic                         mem_enable,
  output logic                         mem_rw,
  output logic [1:0]                   mem_access_size,
  input  logic                         mem_busy,
  input  logic [DATA_WIDTH-1:0]        mem_data_out,
  output logic [DATA_WIDTH-1:0]        insn,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic                         insn_valid,
  input  logic                         decode_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         empty
`ifdef FETCHQ_STALL_COUNT_EN
  ,
  output logic [31:0]                  stall_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [ADDR_WIDTH-1:0]  pc_reg;
  logic                   inflight;
  logic [ADDR_WIDTH-1:0]  inflight_pc;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [LW-1:0]          count;
  logic [DATA_WIDTH-1:0]  insn_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];
  logic [LW:0]            reserved;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   head_valid;

  assign head_valid = (count != '0);

  // Next-state logic plus the issue/push/pop decisions; redirect blocks all three
  always_comb begin
    next_state = state;
    reserved   = {1'b0, count} + (LW+1)'(inflight);
    issue      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: if (enable_fetch)  next_state = RUN;
      RUN:  if (!enable_fetch) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    issue = (state == RUN) && enable_fetch && !mem_busy && !redirect &&
            (reserved < (LW+1)'(DEPTH));
    push  = inflight && !redirect;
    pop   = head_valid && decode_ready && !redirect;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // PC and in-flight tracking; the slot reserved at issue is consumed next cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg      <= START_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc_reg      <= redirect_pc;
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_reg      <= pc_reg + ADDR_WIDTH'(PC_STEP);
        inflight_pc <= pc_reg;
      end
    end
  end

  // Queue pointers and occupancy; redirect empties the queue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

  // Queue storage; contents are only observable through a valid head
  always_ff @(posedge clock) begin
    if (push) begin
      insn_mem[wr_ptr] <= mem_data_out;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

`ifdef FETCHQ_STALL_COUNT_EN
  // Saturating count of cycles where decode is ready but nothing is queued
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (decode_ready && !head_valid && (state == RUN) &&
                 (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

  assign mem_address     = pc_reg;
  assign mem_enable      = issue;
  assign mem_rw          = 1'b1;
  assign mem_access_size = 2'b00;
  assign insn_valid      = head_valid;
  assign insn            = head_valid ? insn_mem[rd_ptr] : '0;
  assign pc              = head_valid ? pc_mem[rd_ptr] : '0;
  assign level           = count;
  assign full            = (count == LW'(DEPTH));
  assign empty           = !head_valid;

endmodule
